softusb_ptx: RTL

- Packet-level USB transmitter for the softusb SIE, successor to the byte-handshake transmitter.
- Adds an internal parametrised byte FIFO with per-byte last-marker, automatic SYNC and EOP generation, and a parametrised bit-rate divider.
- Runtime full-/low-speed selection is latched per packet, plus an underrun abort.
- Sits between the softusb CPU I/O registers and the transceiver pins; it fully handles NRZI encoding and bit stuffing.

---
 rtl/softusb_ptx_pkg.sv | 34 +++
 rtl/softusb_ptx_fifo.sv | 74 +++++++
 rtl/softusb_ptx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/softusb_ptx_pkg.sv
// Shared types and constants for the softusb packet transmitter.
// Holds the FSM encoding, the FIFO entry layout and the per-speed J/K line states.
package softusb_ptx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    STUFF   = 3'd3,
    EOP_SE0 = 3'd4,
    EOP_J   = 3'd5
  } state_e;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam int unsigned STUFF_LIMIT  = 6;

  // {txp, txm} for each line state
  localparam logic [1:0] FS_J     = 2'b10;
  localparam logic [1:0] FS_K     = 2'b01;
  localparam logic [1:0] LS_J     = 2'b01;
  localparam logic [1:0] LS_K     = 2'b10;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  function automatic logic [1:0] line_state(input logic ls, input logic is_j);
    if (ls) return is_j ? LS_J : LS_K;
    return is_j ? FS_J : FS_K;
  endfunction

endpackage

// File: rtl/softusb_ptx_fifo.sv
// Synchronous FIFO of {last, data} entries with occupancy output.
// Fullness and emptiness are registered; a push is judged against fullness before any same-cycle pop.
module softusb_ptx_fifo
  import softusb_ptx_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  fifo_entry_t         wr_entry_i,
  input  logic                rd_en_i,
  output fifo_entry_t         head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] level_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  fifo_entry_t           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  push_c, pop_c;

  assign push_c = wr_en_i && !full_q;
  assign pop_c  = rd_en_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = count_q;

endmodule

// File: rtl/softusb_ptx.sv
// Packet-level USB transmitter: byte FIFO, SYNC/EOP framing, bit stuffing and NRZI line drive.
// Speed is latched per packet; an empty FIFO mid-packet truncates at the byte boundary and flags underrun.
module softusb_ptx
  import softusb_ptx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter int unsigned FS_DIV          = 4,
  parameter int unsigned LS_DIV          = 32
) (
  input  logic                     usb_clk,
  input  logic                     usb_rst,
  input  logic                     low_speed,
  input  logic [7:0]               wr_data,
  input  logic                     wr_last,
  input  logic                     wr_en,
  output logic                     fifo_full,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level,
  input  logic                     start,
  output logic                     busy,
  output logic                     underrun,
  output logic                     txp,
  output logic                     txm,
  output logic                     txoe
);

  localparam int unsigned MAX_DIV = (LS_DIV > FS_DIV) ? LS_DIV : FS_DIV;
  localparam int unsigned TW      = $clog2(MAX_DIV + 1);

  state_e      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        last_q, last_d;
  logic [2:0]  ones_q, ones_d;
  logic        line_j_q, line_j_d;
  logic        ls_q, ls_d;
  logic        underrun_q, underrun_d;
  logic        txp_q, txm_q, txoe_q, busy_q;
  logic        txoe_d, busy_d;
  logic [1:0]  line_d;

  logic        pop_c, emit_c, emit_bit_c, next_byte_c;
  logic [2:0]  nxt_idx_c;
  logic [TW-1:0] div_m1_c;
  fifo_entry_t fifo_head;
  fifo_entry_t wr_entry;
  logic        fifo_empty;

  assign wr_entry = '{last: wr_last, data: wr_data};

  softusb_ptx_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (usb_clk),
    .rst_i     (usb_rst),
    .wr_en_i   (wr_en),
    .wr_entry_i(wr_entry),
    .rd_en_i   (pop_c),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign div_m1_c  = ls_q ? TW'(LS_DIV - 1) : TW'(FS_DIV - 1);
  assign nxt_idx_c = bit_idx_q + 3'd1;

  // State and datapath registers
  always_ff @(posedge usb_clk or posedge usb_rst) begin
    if (usb_rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      ones_q     <= '0;
      line_j_q   <= 1'b1;
      ls_q       <= 1'b0;
      underrun_q <= 1'b0;
      txp_q      <= 1'b1;
      txm_q      <= 1'b0;
      txoe_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      ones_q     <= ones_d;
      line_j_q   <= line_j_d;
      ls_q       <= ls_d;
      underrun_q <= underrun_d;
      txp_q      <= line_d[1];
      txm_q      <= line_d[0];
      txoe_q     <= txoe_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: every bit slot boundary chooses the next bit to put on the line
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    last_d      = last_q;
    ones_d      = ones_q;
    line_j_d    = line_j_q;
    ls_d        = ls_q;
    underrun_d  = underrun_q;
    pop_c       = 1'b0;
    emit_c      = 1'b0;
    emit_bit_c  = 1'b0;
    next_byte_c = 1'b0;

    if (state_q == IDLE) begin
      if (start && !fifo_empty) begin
        state_d    = SYNC;
        ls_d       = low_speed;
        underrun_d = 1'b0;
        timer_d    = low_speed ? TW'(LS_DIV - 1) : TW'(FS_DIV - 1);
        bit_idx_d  = '0;
        shift_d    = SYNC_PATTERN;
        ones_d     = '0;
        emit_c     = 1'b1;
        emit_bit_c = SYNC_PATTERN[0];
      end
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end else begin
      timer_d = div_m1_c;
      unique case (state_q)
        SYNC: begin
          if (bit_idx_q != 3'd7) begin
            bit_idx_d  = nxt_idx_c;
            emit_c     = 1'b1;
            emit_bit_c = shift_q[nxt_idx_c];
          end else begin
            next_byte_c = 1'b1;
          end
        end
        DATA, STUFF: begin
          if (ones_q == 3'(STUFF_LIMIT)) begin
            state_d    = STUFF;
            emit_c     = 1'b1;
            emit_bit_c = 1'b0;
          end else if (bit_idx_q != 3'd7) begin
            state_d    = DATA;
            bit_idx_d  = nxt_idx_c;
            emit_c     = 1'b1;
            emit_bit_c = shift_q[nxt_idx_c];
          end else if (last_q) begin
            state_d   = EOP_SE0;
            bit_idx_d = '0;
          end else if (fifo_empty) begin
            state_d    = EOP_SE0;
            bit_idx_d  = '0;
            underrun_d = 1'b1;
          end else begin
            next_byte_c = 1'b1;
          end
        end
        EOP_SE0: begin
          if (bit_idx_q == 3'd1) begin
            state_d  = EOP_J;
            line_j_d = 1'b1;
          end else begin
            bit_idx_d = nxt_idx_c;
          end
        end
        EOP_J: begin
          state_d = IDLE;
          timer_d = '0;
        end
        default: state_d = IDLE;
      endcase

      if (next_byte_c) begin
        pop_c      = 1'b1;
        state_d    = DATA;
        shift_d    = fifo_head.data;
        last_d     = fifo_head.last;
        bit_idx_d  = '0;
        emit_c     = 1'b1;
        emit_bit_c = fifo_head.data[0];
      end
    end

    // NRZI: a 0 toggles the line, a 1 holds it
    if (emit_c) begin
      line_j_d = emit_bit_c ? line_j_q : ~line_j_q;
      ones_d   = emit_bit_c ? ones_q + 3'd1 : 3'd0;
    end
  end

  // Output decode from the next state so pins change together with the bit
  always_comb begin
    txoe_d = 1'b0;
    busy_d = 1'b0;
    line_d = line_state(ls_d, line_j_d);
    if (state_d != IDLE) begin
      txoe_d = 1'b1;
      busy_d = 1'b1;
    end
    if (state_d == EOP_SE0) line_d = LINE_SE0;
  end

  assign txp      = txp_q;
  assign txm      = txm_q;
  assign txoe     = txoe_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule
